// File: rtl/ahb_rr_arbiter_2.sv
// ahb_rr_arbiter_2
// Two-master AHB-Lite round-robin arbiter that shares one slave port.
// A master that loses arbitration is stalled through its HREADY while its
// address phase is held in a per-master pending buffer. Only NONSEQ/IDLE
// is ever issued on the slave side.
//
// Ports:
//   clock, reset               - sole clock, synchronous active-high reset
//   auto_in_{0,1}_htrans/hsize/hwrite/haddr/hwdata  - master address/wdata
//   auto_in_{0,1}_hready/hresp/hrdata              - master responses
//   auto_out_htrans/hsize/hwrite/haddr/hwdata      - slave-side transfer
//   auto_out_hready            - mirrors auto_out_hreadyout
//   auto_out_hreadyout/hresp/hrdata                - slave response
module ahb_rr_arbiter_2 (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  auto_in_0_htrans,
    input  logic [2:0]  auto_in_0_hsize,
    input  logic        auto_in_0_hwrite,
    input  logic [30:0] auto_in_0_haddr,
    input  logic [31:0] auto_in_0_hwdata,
    output logic        auto_in_0_hready,
    output logic        auto_in_0_hresp,
    output logic [31:0] auto_in_0_hrdata,
    input  logic [1:0]  auto_in_1_htrans,
    input  logic [2:0]  auto_in_1_hsize,
    input  logic        auto_in_1_hwrite,
    input  logic [30:0] auto_in_1_haddr,
    input  logic [31:0] auto_in_1_hwdata,
    output logic        auto_in_1_hready,
    output logic        auto_in_1_hresp,
    output logic [31:0] auto_in_1_hrdata,
    output logic [1:0]  auto_out_htrans,
    output logic [2:0]  auto_out_hsize,
    output logic        auto_out_hwrite,
    output logic [30:0] auto_out_haddr,
    output logic [31:0] auto_out_hwdata,
    output logic        auto_out_hready,
    input  logic        auto_out_hreadyout,
    input  logic        auto_out_hresp,
    input  logic [31:0] auto_out_hrdata
);

    // Per-master views of the live inputs
    logic [1:0]       in_req;
    logic [1:0][2:0]  in_hsize;
    logic [1:0]       in_hwrite;
    logic [1:0][30:0] in_haddr;
    logic [1:0]       in_hready;
    logic [1:0]       live;

    // Pending buffers
    logic [1:0]       pend_valid_q, pend_valid_d;
    logic [1:0][2:0]  pend_hsize_q, pend_hsize_d;
    logic [1:0]       pend_hwrite_q, pend_hwrite_d;
    logic [1:0][30:0] pend_haddr_q, pend_haddr_d;

    // Arbitration / data-phase state
    logic dphase_valid_q, dphase_valid_d;
    logic dphase_owner_q, dphase_owner_d;
    logic lock_valid_q, lock_valid_d;
    logic lock_idx_q, lock_idx_d;
    logic rr_last_q, rr_last_d;

    // Requestor sources and selection
    logic [1:0]       req;
    logic [1:0][2:0]  src_hsize;
    logic [1:0]       src_hwrite;
    logic [1:0][30:0] src_haddr;
    logic             any_req;
    logic             accept;
    logic             sel;

    // htrans[0] only distinguishes SEQ/BUSY, which are not forwarded
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = &{1'b0, auto_in_0_htrans[0], auto_in_1_htrans[0]};

    assign in_req    = {auto_in_1_htrans[1], auto_in_0_htrans[1]};
    assign in_hsize  = {auto_in_1_hsize, auto_in_0_hsize};
    assign in_hwrite = {auto_in_1_hwrite, auto_in_0_hwrite};
    assign in_haddr  = {auto_in_1_haddr, auto_in_0_haddr};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (dphase_valid_q && (dphase_owner_q == i[0])) begin
                in_hready[i] = auto_out_hreadyout;
            end else if (pend_valid_q[i]) begin
                in_hready[i] = 1'b0;
            end else begin
                in_hready[i] = 1'b1;
            end
            live[i]       = in_req[i] && in_hready[i];
            req[i]        = pend_valid_q[i] || live[i];
            src_hsize[i]  = pend_valid_q[i] ? pend_hsize_q[i]  : in_hsize[i];
            src_hwrite[i] = pend_valid_q[i] ? pend_hwrite_q[i] : in_hwrite[i];
            src_haddr[i]  = pend_valid_q[i] ? pend_haddr_q[i]  : in_haddr[i];
        end
    end

    assign any_req = |req;
    assign accept  = any_req && auto_out_hreadyout;

    always_comb begin
        if (lock_valid_q) begin
            sel = lock_idx_q;
        end else if (req[0] && req[1]) begin
            sel = ~rr_last_q;
        end else begin
            sel = req[1];
        end
    end

    // Slave-side outputs
    assign auto_out_htrans = any_req ? 2'b10 : 2'b00;
    assign auto_out_hsize  = any_req ? src_hsize[sel]  : auto_in_0_hsize;
    assign auto_out_hwrite = any_req ? src_hwrite[sel] : auto_in_0_hwrite;
    assign auto_out_haddr  = any_req ? src_haddr[sel]  : auto_in_0_haddr;
    assign auto_out_hwdata = dphase_owner_q ? auto_in_1_hwdata : auto_in_0_hwdata;
    assign auto_out_hready = auto_out_hreadyout;

    // Master-side outputs
    assign auto_in_0_hready = in_hready[0];
    assign auto_in_1_hready = in_hready[1];
    assign auto_in_0_hresp  = dphase_valid_q && !dphase_owner_q && auto_out_hresp;
    assign auto_in_1_hresp  = dphase_valid_q &&  dphase_owner_q && auto_out_hresp;
    assign auto_in_0_hrdata = auto_out_hrdata;
    assign auto_in_1_hrdata = auto_out_hrdata;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_hsize_d  = pend_hsize_q;
        pend_hwrite_d = pend_hwrite_q;
        pend_haddr_d  = pend_haddr_q;
        // Any live request that does not win this cycle (lost, or stalled by
        // a slave wait state) is parked so the slave sees a stable address.
        for (int unsigned i = 0; i < 2; i++) begin
            if (accept && (sel == i[0])) begin
                pend_valid_d[i] = 1'b0;
            end else if (live[i]) begin
                pend_valid_d[i]  = 1'b1;
                pend_hsize_d[i]  = in_hsize[i];
                pend_hwrite_d[i] = in_hwrite[i];
                pend_haddr_d[i]  = in_haddr[i];
            end
        end

        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (any_req) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = sel;
        end

        dphase_valid_d = dphase_valid_q;
        dphase_owner_d = dphase_owner_q;
        if (accept) begin
            dphase_valid_d = 1'b1;
            dphase_owner_d = sel;
        end else if (dphase_valid_q && auto_out_hreadyout) begin
            dphase_valid_d = 1'b0;
        end

        rr_last_d = accept ? sel : rr_last_q;
    end

    always_ff @(posedge clock) begin
        pend_hsize_q   <= pend_hsize_d;
        pend_hwrite_q  <= pend_hwrite_d;
        pend_haddr_q   <= pend_haddr_d;
        dphase_owner_q <= dphase_owner_d;
        lock_idx_q     <= lock_idx_d;
        if (reset) begin
            pend_valid_q   <= '0;
            dphase_valid_q <= 1'b0;
            lock_valid_q   <= 1'b0;
            rr_last_q      <= 1'b1;
        end else begin
            pend_valid_q   <= pend_valid_d;
            dphase_valid_q <= dphase_valid_d;
            lock_valid_q   <= lock_valid_d;
            rr_last_q      <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter_2.sv
// tb_ahb_rr_arbiter_2
// Directed self-checking bench for ahb_rr_arbiter_2. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_ahb_rr_arbiter_2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  in0_htrans, in1_htrans;
    logic [2:0]  in0_hsize, in1_hsize;
    logic        in0_hwrite, in1_hwrite;
    logic [30:0] in0_haddr, in1_haddr;
    logic [31:0] in0_hwdata, in1_hwdata;
    logic        in0_hready, in1_hready;
    logic        in0_hresp, in1_hresp;
    logic [31:0] in0_hrdata, in1_hrdata;
    logic [1:0]  out_htrans;
    logic [2:0]  out_hsize;
    logic        out_hwrite;
    logic [30:0] out_haddr;
    logic [31:0] out_hwdata;
    logic        out_hready;
    logic        out_hreadyout;
    logic        out_hresp;
    logic [31:0] out_hrdata;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    ahb_rr_arbiter_2 dut (
        .clock(clock), .reset(reset),
        .auto_in_0_htrans(in0_htrans), .auto_in_0_hsize(in0_hsize),
        .auto_in_0_hwrite(in0_hwrite), .auto_in_0_haddr(in0_haddr),
        .auto_in_0_hwdata(in0_hwdata), .auto_in_0_hready(in0_hready),
        .auto_in_0_hresp(in0_hresp), .auto_in_0_hrdata(in0_hrdata),
        .auto_in_1_htrans(in1_htrans), .auto_in_1_hsize(in1_hsize),
        .auto_in_1_hwrite(in1_hwrite), .auto_in_1_haddr(in1_haddr),
        .auto_in_1_hwdata(in1_hwdata), .auto_in_1_hready(in1_hready),
        .auto_in_1_hresp(in1_hresp), .auto_in_1_hrdata(in1_hrdata),
        .auto_out_htrans(out_htrans), .auto_out_hsize(out_hsize),
        .auto_out_hwrite(out_hwrite), .auto_out_haddr(out_haddr),
        .auto_out_hwdata(out_hwdata), .auto_out_hready(out_hready),
        .auto_out_hreadyout(out_hreadyout), .auto_out_hresp(out_hresp),
        .auto_out_hrdata(out_hrdata)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        in0_htrans = 2'b00; in0_hsize = 3'd2; in0_hwrite = 1'b0; in0_haddr = '0; in0_hwdata = '0;
        in1_htrans = 2'b00; in1_hsize = 3'd2; in1_hwrite = 1'b0; in1_haddr = '0; in1_hwdata = '0;
        out_hreadyout = 1'b1; out_hresp = 1'b0; out_hrdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            out_hreadyout = c[0];
            @(negedge clock);
            checks++;
            if ({in0_hready, in1_hready, in0_hresp, in1_hresp, out_htrans, out_hready} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, c[0]})
                $display("FAIL reset_idle cyc%0d: got h0=%b h1=%b r0=%b r1=%b tr=%b ordy=%b, want 1 1 0 0 00 %b",
                         c, in0_hready, in1_hready, in0_hresp, in1_hresp, out_htrans, out_hready, c[0]);
            else passed++;
            cyc();
        end
        out_hreadyout = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        in0_htrans = 2'b10; in0_hwrite = 1'b1; in0_haddr = 31'h1000_0004;
        @(negedge clock);
        checks++;
        if ({out_htrans, out_haddr, out_hwrite, in0_hready} !== {2'b10, 31'h1000_0004, 1'b1, 1'b1})
            $display("FAIL single_addr: got tr=%b a=%h w=%b h0=%b, want 10 10000004 1 1",
                     out_htrans, out_haddr, out_hwrite, in0_hready);
        else passed++;
        cyc();
        in0_htrans = 2'b00; in0_hwdata = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++;
        if ({out_hwdata, in0_hready, out_htrans} !== {32'hDEAD_BEEF, 1'b1, 2'b00})
            $display("FAIL single_data: got wd=%h h0=%b tr=%b, want deadbeef 1 00",
                     out_hwdata, in0_hready, out_htrans);
        else passed++;
        cyc();
    endtask

    task automatic test_collision();
        do_reset();
        in0_htrans = 2'b10; in0_haddr = 31'h100;
        in1_htrans = 2'b10; in1_haddr = 31'h200;
        @(negedge clock);
        checks++;
        if ({out_haddr, in0_hready, in1_hready} !== {31'h100, 1'b1, 1'b1})
            $display("FAIL coll_c0: got a=%h h0=%b h1=%b, want 100 1 1", out_haddr, in0_hready, in1_hready);
        else passed++;
        cyc();
        in0_htrans = 2'b00; in1_htrans = 2'b00; out_hrdata = 32'hAAAA_0000;
        @(negedge clock);
        checks++;
        if ({out_htrans, out_haddr, in1_hready, in0_hready, in0_hrdata} !==
            {2'b10, 31'h200, 1'b0, 1'b1, 32'hAAAA_0000})
            $display("FAIL coll_c1: got tr=%b a=%h h1=%b h0=%b rd0=%h, want 10 200 0 1 aaaa0000",
                     out_htrans, out_haddr, in1_hready, in0_hready, in0_hrdata);
        else passed++;
        cyc();
        out_hrdata = 32'hBBBB_0000;
        @(negedge clock);
        checks++;
        if ({in1_hready, in1_hrdata, out_htrans} !== {1'b1, 32'hBBBB_0000, 2'b00})
            $display("FAIL coll_c2: got h1=%b rd1=%h tr=%b, want 1 bbbb0000 00",
                     in1_hready, in1_hrdata, out_htrans);
        else passed++;
        cyc();
    endtask

    task automatic test_wait_lock();
        do_reset();
        out_hreadyout = 1'b0;
        in1_htrans = 2'b10; in1_haddr = 31'h300;
        @(negedge clock);
        checks++;
        if ({out_htrans, out_haddr, in1_hready} !== {2'b10, 31'h300, 1'b1})
            $display("FAIL lock_c0: got tr=%b a=%h h1=%b, want 10 300 1", out_htrans, out_haddr, in1_hready);
        else passed++;
        cyc();
        in1_htrans = 2'b00; in1_haddr = 31'h7FF;
        in0_htrans = 2'b10; in0_haddr = 31'h400;
        @(negedge clock);
        checks++;
        if ({out_haddr, in1_hready, in0_hready} !== {31'h300, 1'b0, 1'b1})
            $display("FAIL lock_c1: got a=%h h1=%b h0=%b, want 300 0 1", out_haddr, in1_hready, in0_hready);
        else passed++;
        cyc();
        in0_htrans = 2'b00; in0_haddr = 31'h7EE;
        @(negedge clock);
        checks++;
        if ({out_htrans, out_haddr, in0_hready, in1_hready} !== {2'b10, 31'h300, 1'b0, 1'b0})
            $display("FAIL lock_c2: got tr=%b a=%h h0=%b h1=%b, want 10 300 0 0",
                     out_htrans, out_haddr, in0_hready, in1_hready);
        else passed++;
        cyc();
        out_hreadyout = 1'b1;
        @(negedge clock);
        checks++;
        if ({out_haddr, in0_hready} !== {31'h300, 1'b0})
            $display("FAIL lock_c3: got a=%h h0=%b, want 300 0", out_haddr, in0_hready);
        else passed++;
        cyc();
        @(negedge clock);
        checks++;
        if ({out_htrans, out_haddr, in1_hready, in0_hready} !== {2'b10, 31'h400, 1'b1, 1'b0})
            $display("FAIL lock_c4: got tr=%b a=%h h1=%b h0=%b, want 10 400 1 0",
                     out_htrans, out_haddr, in1_hready, in0_hready);
        else passed++;
        cyc();
        @(negedge clock);
        checks++;
        if ({out_htrans, in0_hready} !== {2'b00, 1'b1})
            $display("FAIL lock_c5: got tr=%b h0=%b, want 00 1", out_htrans, in0_hready);
        else passed++;
        cyc();
    endtask

    task automatic test_fairness();
        int n0, n1, acc, last_cyc;
        logic h0, h1;
        logic [30:0] exp_addr;
        do_reset();
        n0 = 0; n1 = 0; acc = 0; last_cyc = -1;
        for (int c = 0; c < 40 && acc < 16; c++) begin
            in0_htrans = (n0 < 8) ? 2'b10 : 2'b00;
            in0_haddr  = 31'(n0 * 4);
            in1_htrans = (n1 < 8) ? 2'b10 : 2'b00;
            in1_haddr  = 31'h8000 + 31'(n1 * 4);
            @(negedge clock);
            h0 = in0_hready; h1 = in1_hready;
            if (out_htrans == 2'b10 && out_hreadyout) begin
                exp_addr = (acc % 2 == 0) ? 31'((acc / 2) * 4) : 31'h8000 + 31'((acc / 2) * 4);
                checks++;
                if (out_haddr !== exp_addr)
                    $display("FAIL fair_xfer%0d: got addr=%h, want %h", acc, out_haddr, exp_addr);
                else passed++;
                acc++;
                last_cyc = c;
            end
            cyc();
            if (h0 && in0_htrans[1]) n0++;
            if (h1 && in1_htrans[1]) n1++;
        end
        checks++;
        if (acc !== 16 || last_cyc !== 15)
            $display("FAIL fair_count: got %0d transfers ending cycle %0d, want 16 ending cycle 15", acc, last_cyc);
        else passed++;
        idle_all();
        cyc();
    endtask

    task automatic test_error_reset();
        do_reset();
        in0_htrans = 2'b10; in0_haddr = 31'h500;
        @(negedge clock);
        checks++;
        if ({out_haddr, in0_hresp} !== {31'h500, 1'b0})
            $display("FAIL err_addr: got a=%h r0=%b, want 500 0", out_haddr, in0_hresp);
        else passed++;
        cyc();
        in0_htrans = 2'b00; out_hreadyout = 1'b0; out_hresp = 1'b1;
        @(negedge clock);
        checks++;
        if ({in0_hresp, in0_hready, in1_hresp, in1_hready} !== {1'b1, 1'b0, 1'b0, 1'b1})
            $display("FAIL err_c1: got r0=%b h0=%b r1=%b h1=%b, want 1 0 0 1",
                     in0_hresp, in0_hready, in1_hresp, in1_hready);
        else passed++;
        cyc();
        out_hreadyout = 1'b1;
        @(negedge clock);
        checks++;
        if ({in0_hresp, in0_hready, in1_hresp} !== {1'b1, 1'b1, 1'b0})
            $display("FAIL err_c2: got r0=%b h0=%b r1=%b, want 1 1 0", in0_hresp, in0_hready, in1_hresp);
        else passed++;
        cyc();
        @(negedge clock);
        checks++;
        if ({in0_hresp, in1_hresp} !== 2'b00)
            $display("FAIL err_c3: got r0=%b r1=%b, want 0 0", in0_hresp, in1_hresp);
        else passed++;
        cyc();
        out_hresp = 1'b0;

        // Reset while master 1 sits in its pending buffer
        do_reset();
        in0_htrans = 2'b10; in0_haddr = 31'h600;
        in1_htrans = 2'b10; in1_haddr = 31'h700;
        cyc();
        in0_htrans = 2'b00; in1_htrans = 2'b00; reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in1_hready !== 1'b0)
            $display("FAIL rst_pend_before: got h1=%b, want 0", in1_hready);
        else passed++;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({in1_hready, out_htrans} !== {1'b1, 2'b00})
            $display("FAIL rst_pend_after: got h1=%b tr=%b, want 1 00", in1_hready, out_htrans);
        else passed++;
        cyc();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single();
        test_collision();
        test_wait_lock();
        test_fairness();
        test_error_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
